// File: rtl/radix4_mult_ctrl_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: FSM state and Booth digit encodings.
package radix4_mult_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        DIG_ZERO = 3'd0,
        DIG_P1   = 3'd1,
        DIG_P2   = 3'd2,
        DIG_M1   = 3'd3,
        DIG_M2   = 3'd4
    } booth_digit_e;

endpackage

// File: rtl/fa_cell.sv
// Single-bit full adder cell.
//   a, b : addend bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/radix4_booth_enc.sv
// Combinational radix-4 Booth recoder for one multiplier bit triple.
//   bits  : {b[2i+1], b[2i], b[2i-1]}
//   digit : booth_digit_e code (ZERO, P1, P2, M1, M2)
//   neg   : digit is negative (subtract)
//   dbl   : digit magnitude is 2 (use 2A)
module radix4_booth_enc
    import radix4_mult_ctrl_pkg::*;
(
    input  logic [2:0] bits,
    output logic [2:0] digit,
    output logic       neg,
    output logic       dbl
);

    always_comb begin
        digit = DIG_ZERO;
        neg   = 1'b0;
        dbl   = 1'b0;
        case (bits)
            3'b000, 3'b111: digit = DIG_ZERO;
            3'b001, 3'b010: digit = DIG_P1;
            3'b011: begin
                digit = DIG_P2;
                dbl   = 1'b1;
            end
            3'b100: begin
                digit = DIG_M2;
                neg   = 1'b1;
                dbl   = 1'b1;
            end
            default: begin
                digit = DIG_M1;
                neg   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/radix4_mult_ctrl_addsub.sv
// Ripple-carry adder/subtractor built from a chain of fa_cell instances.
//   op_a : minuend / first addend
//   op_b : second operand, inverted when sub=1
//   sub  : 1 = op_a - op_b (inverted operand, carry-in 1)
//   sum  : W-bit result (carry out discarded, arithmetic is modulo 2^W)
module radix4_mult_ctrl_addsub #(
    parameter int unsigned W = 18
) (
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         sub,
    output logic [W-1:0] sum
);

    logic [W-1:0] op_b_eff;
    logic [W-1:0] carry;
    logic         cout_unused;

    assign op_b_eff = op_b ^ {W{sub}};
    assign carry[0] = sub;

    for (genvar i = 0; i < W; i++) begin : g_bit
        if (i < W - 1) begin : g_mid
            fa_cell u_fa (
                .a  (op_a[i]),
                .b  (op_b_eff[i]),
                .ci (carry[i]),
                .s  (sum[i]),
                .co (carry[i+1])
            );
        end else begin : g_msb
            fa_cell u_fa (
                .a  (op_a[i]),
                .b  (op_b_eff[i]),
                .ci (carry[i]),
                .s  (sum[i]),
                .co (cout_unused)
            );
        end
    end

endmodule

// File: rtl/radix4_mult_ctrl.sv
// Sequential radix-4 Booth multiplier: one Booth digit per cycle through a
// shared ripple adder/subtractor.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request a multiply of a*b (ignored while busy)
//   a, b       : WIDTH-bit operands (two's complement)
//   tc         : only with RADIX4_MULT_UNSIGNED_EN; 1 = signed, 0 = unsigned
//   busy       : high in LOAD and ITER
//   done       : one-cycle pulse, product valid
//   product    : 2*WIDTH-bit result, updated on entry to DONE only
// Optional feature macro: RADIX4_MULT_UNSIGNED_EN adds the tc port and the
// unsigned mode (one extra digit).
module radix4_mult_ctrl
    import radix4_mult_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef RADIX4_MULT_UNSIGNED_EN
    input  logic                 tc,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned N  = WIDTH / 2;
    localparam int unsigned XW = WIDTH + 2;
    localparam int unsigned AW = 2 * WIDTH + 2;
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(N + 2);

    state_e          state_q, state_d;
    logic [XW-1:0]   a_q, a_d;
    logic [XW:0]     b_q, b_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            rdy_q;

    logic            ext_a, ext_b;
    logic [CW-1:0]   last_cnt;
    logic [2:0]      dig_bits;
    logic [2:0]      dig;
    logic            dig_neg, dig_dbl;
    logic [AW-1:0]   a_sx, pp_mag, pp, pp_sh, acc_sum;

`ifdef RADIX4_MULT_UNSIGNED_EN
    logic            tc_q, tc_d;

    // Unsigned operands are zero-extended and need one extra digit.
    assign ext_a    = tc & a[WIDTH-1];
    assign ext_b    = tc & b[WIDTH-1];
    assign last_cnt = tc_q ? CW'(N - 1) : CW'(N);
`else
    assign ext_a    = a[WIDTH-1];
    assign ext_b    = b[WIDTH-1];
    assign last_cnt = CW'(N - 1);
`endif

    // Current bit triple; b_q carries the implicit b[-1]=0 in bit 0.
    assign dig_bits = b_q[{cnt_q, 1'b0} +: 3];

    radix4_booth_enc u_enc (
        .bits  (dig_bits),
        .digit (dig),
        .neg   (dig_neg),
        .dbl   (dig_dbl)
    );

    // Partial product: sign-extended A (or 2A), weighted by 4^cnt.
    assign a_sx   = {{(AW - XW){a_q[XW-1]}}, a_q};
    assign pp_mag = dig_dbl ? {a_sx[AW-2:0], 1'b0} : a_sx;
    assign pp     = (dig != DIG_ZERO) ? pp_mag : '0;
    assign pp_sh  = pp << {cnt_q, 1'b0};

    radix4_mult_ctrl_addsub #(.W(AW)) u_addsub (
        .op_a (acc_q),
        .op_b (pp_sh),
        .sub  (dig_neg),
        .sum  (acc_sum)
    );

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
`ifdef RADIX4_MULT_UNSIGNED_EN
        tc_d    = tc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && rdy_q) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                a_d     = {{2{ext_a}}, a};
                b_d     = {{2{ext_b}}, b, 1'b0};
                acc_d   = '0;
                cnt_d   = '0;
`ifdef RADIX4_MULT_UNSIGNED_EN
                tc_d    = tc;
`endif
                state_d = ST_ITER;
            end
            ST_ITER: begin
                acc_d = acc_sum;
                if (cnt_q == last_cnt) begin
                    prod_d  = acc_sum[PW-1:0];
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = start ? ST_LOAD : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_LOAD) || (state_d == ST_ITER);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef RADIX4_MULT_UNSIGNED_EN
            tc_q    <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef RADIX4_MULT_UNSIGNED_EN
            tc_q    <= tc_d;
`endif
        end
    end

    // Blocks start on the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = prod_q;

endmodule

// File: tb/tb_radix4_mult_ctrl.sv
// Directed self-checking bench for radix4_mult_ctrl (WIDTH=8).
// Unsigned-mode vectors run only when RADIX4_MULT_UNSIGNED_EN is defined.
module tb_radix4_mult_ctrl;
    import radix4_mult_ctrl_pkg::*;

    localparam int unsigned WIDTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
`ifdef RADIX4_MULT_UNSIGNED_EN
    logic        tc;
`endif
    logic        busy;
    logic        done;
    logic [15:0] product;

    int checks   = 0;
    int failures = 0;
    logic seen_done;

    always #5 clk = ~clk;

    radix4_mult_ctrl #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
`ifdef RADIX4_MULT_UNSIGNED_EN
        .tc      (tc),
`endif
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start at cycle 0, expect busy for cycles 1..n+1, done at n+2, then held product.
    task automatic run_mult(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                            input int n, input logic [15:0] exp);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= n + 1; k++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_nodone"}, 32'(done), 32'd0);
            step();
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        check({tag, "_product"}, 32'(product), 32'(exp));
        step();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_held"}, 32'(product), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = 8'd0;
        b     = 8'd0;
`ifdef RADIX4_MULT_UNSIGNED_EN
        tc    = 1'b1;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));

        // start high across reset release must not be taken on the first edge
        a     = 8'd3;
        b     = 8'd5;
        start = 1'b1;
        rst_n = 1'b1;
        step();
        check("release_no_start", 32'(dut.state_q), 32'(ST_IDLE));
        check("release_busy", 32'(busy), 32'd0);
        start = 1'b0;
        step();

        run_mult("m3x5", 8'd3, 8'd5, 4, 16'd15);
        run_mult("mn128sq", 8'h80, 8'h80, 4, 16'h4000);
        run_mult("m127xn128", 8'h7F, 8'h80, 4, 16'hC080);
        run_mult("mn7x6", 8'hF9, 8'h06, 4, 16'hFFD6);
        run_mult("mn128x1", 8'h80, 8'h01, 4, 16'hFF80);

        // start re-pulsed while busy is ignored; start held in DONE chains back-to-back
        a     = 8'd5;
        b     = 8'd7;
        start = 1'b1;
        step();                                   // cycle 1
        start = 1'b0;
        step();                                   // cycle 2
        step();                                   // cycle 3
        a     = 8'd9;
        b     = 8'd11;
        start = 1'b1;
        step();                                   // cycle 4
        start = 1'b0;
        check("b2b_ignore_state", 32'(dut.state_q), 32'(ST_ITER));
        check("b2b_ignore_busy", 32'(busy), 32'd1);
        step();                                   // cycle 5
        step();                                   // cycle 6
        check("b2b_first_done", 32'(done), 32'd1);
        check("b2b_first_product", 32'(product), 32'd35);
        start = 1'b1;
        step();                                   // cycle 7
        start = 1'b0;
        check("b2b_load_state", 32'(dut.state_q), 32'(ST_LOAD));
        check("b2b_load_busy", 32'(busy), 32'd1);
        for (int c = 8; c <= 11; c++) begin
            step();
            check("b2b_second_busy", 32'(busy), 32'd1);
            check("b2b_second_nodone", 32'(done), 32'd0);
            check("b2b_product_stable", 32'(product), 32'd35);
        end
        step();                                   // cycle 12
        check("b2b_second_done", 32'(done), 32'd1);
        check("b2b_second_product", 32'(product), 32'd99);
        step();

        // reset in the middle of a multiply aborts it
        a     = 8'hFF;
        b     = 8'h01;
        start = 1'b1;
        step();                                   // cycle 1
        start = 1'b0;
        step();                                   // cycle 2
        step();                                   // cycle 3
        step();                                   // cycle 4
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        check("abort_state", 32'(dut.state_q), 32'(ST_IDLE));
        step();
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            seen_done = seen_done | done;
        end
        check("abort_no_done", 32'(seen_done), 32'd0);
        check("abort_idle", 32'(dut.state_q), 32'(ST_IDLE));
        run_mult("mn1x1", 8'hFF, 8'h01, 4, 16'hFFFF);

`ifdef RADIX4_MULT_UNSIGNED_EN
        tc = 1'b0;
        run_mult("u255sq", 8'hFF, 8'hFF, 5, 16'hFE01);
        tc = 1'b1;
        run_mult("s255sq", 8'hFF, 8'hFF, 4, 16'h0001);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
